// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light request conditioner.
// Holds next_req encodings, request slot indices and parameter defaults.
package tlc_pkg;

    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_AGE_W      = 6;
    localparam int DEF_MAX_WAIT   = 30;

    localparam int NUM_REQ = 3;

    // Slot order doubles as tie-break order (lowest slot wins).
    localparam int SL_T34 = 0;
    localparam int SL_P5  = 1;
    localparam int SL_P6  = 2;

    typedef enum logic [1:0] {
        NR_NONE = 2'd0,
        NR_T34  = 2'd1,
        NR_P5   = 2'd2,
        NR_P6   = 2'd3
    } next_req_e;

    function automatic next_req_e slot_code(input int slot);
        case (slot)
            SL_T34:  return NR_T34;
            SL_P5:   return NR_P5;
            default: return NR_P6;
        endcase
    endfunction

endpackage

// File: rtl/tlc_debounce.sv
// Two-flop synchroniser, debounce counter and press (0->1) pulse.
// Ports: clk, reset (async high), raw (async in), press (1-cycle pulse).
module tlc_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            stable      <= 1'b0;
            stable_prev <= 1'b0;
            cnt         <= '0;
        end else begin
            sync1       <= raw;
            sync2       <= sync1;
            stable_prev <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // DEB_CYCLES consecutive differing samples: accept.
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = stable & ~stable_prev;

endmodule

// File: rtl/tlc_request_conditioner.sv
// Conditions raw pedestrian/detector inputs into sticky, aged requests.
// Ports: clk, reset (async high), btn5_raw/btn6_raw/det34_raw (async),
//   tick, clr5/clr6/clr34 in; req5/req6/req34, req_any, urgent,
//   next_req[1:0] (0 none, 1 T34, 2 crossing 5, 3 crossing 6) out.
module tlc_request_conditioner
    import tlc_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int AGE_W      = DEF_AGE_W,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn5_raw,
    input  logic       btn6_raw,
    input  logic       det34_raw,
    input  logic       tick,
    input  logic       clr5,
    input  logic       clr6,
    input  logic       clr34,
    output logic       req5,
    output logic       req6,
    output logic       req34,
    output logic       req_any,
    output logic       urgent,
    output logic [1:0] next_req
);

    localparam logic [AGE_W-1:0] AGE_SAT  = '1;
    localparam logic [AGE_W-1:0] WAIT_LIM = AGE_W'(MAX_WAIT);

    logic [NUM_REQ-1:0] raw_in;
    logic [NUM_REQ-1:0] clr_in;
    logic [NUM_REQ-1:0] press;
    logic [NUM_REQ-1:0] req_q;
    logic [AGE_W-1:0]   age_q [NUM_REQ];

    logic [AGE_W-1:0]   best_age;
    logic               found;
    next_req_e          nr_d;
    logic               urgent_d;

    assign raw_in[SL_T34] = det34_raw;
    assign raw_in[SL_P5]  = btn5_raw;
    assign raw_in[SL_P6]  = btn6_raw;
    assign clr_in[SL_T34] = clr34;
    assign clr_in[SL_P5]  = clr5;
    assign clr_in[SL_P6]  = clr6;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_deb
        tlc_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_in[g]),
            .press(press[g])
        );
    end

    // Clear beats set: a press landing with the clear is already served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (clr_in[i]) begin
                    req_q[i] <= 1'b0;
                    age_q[i] <= '0;
                end else if (req_q[i]) begin
                    if (tick && age_q[i] != AGE_SAT) begin
                        age_q[i] <= age_q[i] + AGE_W'(1);
                    end
                end else if (press[i]) begin
                    req_q[i] <= 1'b1;
                    age_q[i] <= '0;
                end
            end
        end
    end

    // Strict '>' keeps the earlier slot on ties.
    always_comb begin
        best_age = '0;
        found    = 1'b0;
        nr_d     = NR_NONE;
        urgent_d = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_q[i] && (!found || age_q[i] > best_age)) begin
                found    = 1'b1;
                best_age = age_q[i];
                nr_d     = slot_code(i);
            end
            if (req_q[i] && age_q[i] >= WAIT_LIM) begin
                urgent_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_any  <= 1'b0;
            urgent   <= 1'b0;
            next_req <= NR_NONE;
        end else begin
            req_any  <= |req_q;
            urgent   <= urgent_d;
            next_req <= nr_d;
        end
    end

    assign req5  = req_q[SL_P5];
    assign req6  = req_q[SL_P6];
    assign req34 = req_q[SL_T34];

endmodule

// File: doc/tlc_request_conditioner.md
Name: tlc_request_conditioner

Overview:
Upstream conditioning stage for the traffic_lights controller. It takes three raw asynchronous inputs: the pedestrian buttons for crossings 5 and 6 and the side-road (T34) vehicle detector. It synchronises and debounces them, latches sticky service requests and ages them against the controller's timebase tick. The controller reads the sticky requests, an urgent flag and a priority-encoded next_req, and returns per-request clear pulses when the matching green phase starts.

Parameters:
DEB_CYCLES, 4, consecutive clk cycles a synchronised input must differ from its stable value before the stable value flips (>=2)
AGE_W, 6, width of each request age counter (saturating)
MAX_WAIT, 30, age in ticks at or above which a pending request is urgent (< 2^AGE_W)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
btn5_raw  input  1  crossing-5 pedestrian button, asynchronous, active-high
btn6_raw  input  1  crossing-6 pedestrian button, asynchronous, active-high
det34_raw  input  1  T34 side-road vehicle detector, asynchronous, active-high
tick  input  1  one-cycle timebase pulse from controller (one per counter step)
clr5  input  1  one-cycle pulse: crossing 5 green started, request served
clr6  input  1  one-cycle pulse: crossing 6 green started
clr34  input  1  one-cycle pulse: T34 green started
req5  output  1  sticky crossing-5 request
req6  output  1  sticky crossing-6 request
req34  output  1  sticky side-road request
req_any  output  1  OR of the three requests (registered)
urgent  output  1  any pending request with age >= MAX_WAIT
next_req  output  2  request to serve next: 0 none, 1 T34, 2 crossing 5, 3 crossing 6

Behaviour:
- Reset (async, active-high): sync flops, stable values, debounce counters, requests and ages are cleared to 0. Every output is 0 during reset and on the first edge after release.
- Per input: two-flop synchroniser, then debounce.
  - Debounce counter increments while the synchronised value differs from the stable value and clears whenever they match.
  - When the counter reaches DEB_CYCLES-1 and the value still differs, the stable value flips and the counter clears.
- Press = rising edge of the stable value (0->1). Releases and glitches shorter than DEB_CYCLES cycles produce nothing.
- Request set: on a press. Request clear: on the matching clr pulse. If a press and a clr arrive in the same cycle, the clear wins; that press is treated as served by the starting phase.
- A press while the request is already pending has no effect; the age is not restarted.
- Latency: if raw rises before edge 1 and stays high, stable flips at edge 2+DEB_CYCLES and req at edge 3+DEB_CYCLES (7 edges at the default).
- Age: each pending request's counter increments on tick and saturates at 2^AGE_W-1. It is 0 while not pending and is cleared together with the request.
- urgent and next_req are registered, updated one cycle after request and age state.
- next_req selects the pending request with the largest age. Ties go in fixed order T34 > 5 > 6. The value is 0 when nothing is pending.
- Clear pulses for non-pending requests are ignored. The tick and clr inputs are synchronous to clk.

Decomposition:
- Shared package tlc_pkg: next_req encodings NR_NONE=0, NR_T34=1, NR_P5=2, NR_P6=3, plus default DEB_CYCLES, AGE_W and MAX_WAIT.
- One sub-module, tlc_debounce: synchroniser, debounce counter and rising-edge press pulse. Instantiated three times, parameterised by DEB_CYCLES.
- Request latches, ages and the priority encoder stay in the top module.

Test Plan:
- Reset mid-operation: with req5=1 and age 10, assert reset asynchronously between edges -> all outputs 0 immediately, no press after release.
- Debounce: btn5_raw high 3 cycles then low (DEB_CYCLES=4) -> req5 stays 0. btn5_raw held high -> req5=1 exactly 7 edges after the rise, req_any=1 one cycle later.
- Clear/set collision: pending req6 with a clr6 pulse on the same cycle as a new debounced press -> req6=0, age 0. A second press later -> req6=1.
- Aging and urgency (MAX_WAIT=30): req34 pending, 30 ticks -> urgent=1 and next_req=1. clr34 -> urgent=0 and next_req=0 the following cycle.
- Priority: req5 set, 2 ticks, then req34 set -> next_req=2. Clear req5 -> next_req=1. Set req6 and req34 with equal age -> next_req=1 (tie order).
- Saturation (AGE_W=3): request pending for 10 ticks -> age holds at 7, no wrap, urgent stays asserted if MAX_WAIT<=7.
